// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a sync_fifo and its producer/consumer.
// Optional sticky error flags exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8
);

   logic                  write_en;
   logic                  read_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  empty;
   logic                  full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic                  overflow;
   logic                  underflow;
`endif

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   modport master (
      output write_en, read_en, data_in,
      input  data_out, empty, full, overflow, underflow
   );

   modport slave (
      input  write_en, read_en, data_in,
      output data_out, empty, full, overflow, underflow
   );
`else
   modport master (
      output write_en, read_en, data_in,
      input  data_out, empty, full
   );

   modport slave (
      input  write_en, read_en, data_in,
      output data_out, empty, full
   );
`endif

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered read port.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module sync_fifo #(
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned DEPTH      = 16,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input logic        clk,
   input logic        rst,
   sync_fifo_if.slave bus
);

   localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]  wptr;
   logic [PTR_WIDTH-1:0]  rptr;
   logic [DATA_WIDTH-1:0] data_out_q;

   logic                  empty_c;
   logic                  full_c;
   logic                  write_ok_c;
   logic                  read_ok_c;
   logic [ADDR_WIDTH-1:0] waddr_c;
   logic [ADDR_WIDTH-1:0] raddr_c;

   // Flags come straight from the registered pointers; the wrap bit separates full from empty.
   always_comb begin
      waddr_c    = wptr[ADDR_WIDTH-1:0];
      raddr_c    = rptr[ADDR_WIDTH-1:0];
      empty_c    = (wptr == rptr);
      full_c     = (waddr_c == raddr_c) && (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
      write_ok_c = bus.write_en & ~full_c;
      read_ok_c  = bus.read_en  & ~empty_c;
   end

   // Pointer and read-data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         data_out_q <= '0;
      end else begin
         if (write_ok_c) begin
            wptr <= wptr + PTR_WIDTH'(1);
         end
         if (read_ok_c) begin
            data_out_q <= mem[raddr_c];
            rptr       <= rptr + PTR_WIDTH'(1);
         end
      end
   end

   // Storage array is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (!rst && write_ok_c) begin
         mem[waddr_c] <= bus.data_in;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.empty    = empty_c;
   assign bus.full     = full_c;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.write_en && full_c) begin
            overflow_q <= 1'b1;
         end
         if (bus.read_en && empty_c) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based occupancy model.
module tb_sync_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   sync_fifo_if #(.DATA_WIDTH(DW)) bus_if ();

   sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] exp_dout;
   logic          exp_ovf;
   logic          exp_unf;
   logic          seen_aa;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".data_out"}, 32'(bus_if.data_out), 32'(exp_dout));
      check({tag, ".empty"}, 32'(bus_if.empty), 32'(model_q.size() == 0));
      check({tag, ".full"}, 32'(bus_if.full), 32'(model_q.size() == DEPTH));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      check({tag, ".overflow"}, 32'(bus_if.overflow), 32'(exp_ovf));
      check({tag, ".underflow"}, 32'(bus_if.underflow), 32'(exp_unf));
`endif
   endtask

   // One clock: drive on the falling edge, update the model at the rising edge, check 1ns later.
   task automatic step(input logic we, input logic re, input logic [DW-1:0] din, input string tag);
      logic acc_w;
      logic acc_r;
      @(negedge clk);
      bus_if.write_en = we;
      bus_if.read_en  = re;
      bus_if.data_in  = din;
      acc_w = we && (model_q.size() < DEPTH);
      acc_r = re && (model_q.size() > 0);
      if (we && model_q.size() == DEPTH) exp_ovf = 1'b1;
      if (re && model_q.size() == 0)     exp_unf = 1'b1;
      @(posedge clk);
      if (acc_r) exp_dout = model_q.pop_front();
      if (acc_w) model_q.push_back(din);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst             = 1'b1;
      bus_if.write_en = 1'b1;
      bus_if.read_en  = 1'b1;
      bus_if.data_in  = 8'hEE;
      @(posedge clk);
      model_q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      #1;
      check_all(tag);
      @(negedge clk);
      rst             = 1'b0;
      bus_if.write_en = 1'b0;
      bus_if.read_en  = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] pat;
      int unsigned   wbias;
      bus_if.write_en = 1'b0;
      bus_if.read_en  = 1'b0;
      bus_if.data_in  = '0;
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      seen_aa  = 1'b0;

      // Power-up reset.
      do_reset("reset");

      // Fill with 0x01..0x10.
      for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DW'(i), "fill");
      check("fill.full_after_16", 32'(bus_if.full), 32'd1);

      // Write while full is dropped.
      step(1'b1, 1'b0, 8'hAA, "overflow");

      // Drain past empty; data_out must hold 0x10 afterward.
      for (int i = 0; i < 18; i++) begin
         step(1'b0, 1'b1, 8'h00, "drain");
         if (bus_if.data_out === 8'hAA) seen_aa = 1'b1;
      end
      check("drain.hold_last", 32'(bus_if.data_out), 32'h10);
      check("drain.no_aa", 32'(seen_aa), 32'd0);
      check("drain.empty", 32'(bus_if.empty), 32'd1);

      // Simultaneous read/write at occupancy 3 across pointer wrap.
      do_reset("reset2");
      pat = 8'h20;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, pat, "preload");
         pat = pat + 8'd1;
      end
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, pat, "concurrent");
         pat = pat + 8'd1;
      end
      check("concurrent.occupancy", 32'(model_q.size()), 32'd3);
      check("concurrent.last_out", 32'(bus_if.data_out), 32'(8'h20 + 8'd39));

      // Read and write together on a full FIFO: only the read is accepted.
      for (int i = 0; i < 13; i++) step(1'b1, 1'b0, DW'(8'h80 + i), "refill");
      step(1'b1, 1'b1, 8'hBB, "full_rw");
      // And on an empty FIFO: only the write is accepted, no fall-through.
      do_reset("reset3");
      step(1'b1, 1'b1, 8'h33, "empty_rw");
      step(1'b0, 1'b1, 8'h00, "empty_rw_read");

      // Mid-operation reset discards contents.
      do_reset("reset4");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h40 + i), "pre_reset");
      do_reset("mid_reset");
      step(1'b1, 1'b0, 8'h5A, "post_reset_wr");
      step(1'b0, 1'b1, 8'h00, "post_reset_rd");
      check("post_reset.value", 32'(bus_if.data_out), 32'h5A);

      // Randomized traffic with shifting write bias to visit full and empty.
      do_reset("reset5");
      for (int i = 0; i < 400; i++) begin
         wbias = ((i / 50) % 2 == 0) ? 3 : 1;
         if ($urandom_range(0, 127) == 0) begin
            do_reset("rand_reset");
         end else begin
            step(($urandom_range(0, 3) < wbias), ($urandom_range(0, 3) >= wbias - 1),
                 DW'($urandom), "random");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
